dmem_byte_ram: RTL and testbench



---
 rtl/dmem_byte_ram.sv | 74 +++++++
 tb/tb_dmem_byte_ram.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram
// Word-organised data memory for the MEM stage of the 5-stage pipelined CPU.
// It has per-byte write enables and a registered load output. The storage
// array is never cleared by reset, so its contents can be preloaded
// hierarchically through mem[k] before reset is released.
//
// Ports:
//   clk      - single clock; all state changes occur on the rising edge
//   rst      - asynchronous, active-high reset; clears data_out, blocks access
//   RD       - read strobe from the CPU load path
//   WR       - write strobe from the CPU store path
//   addr     - byte address; word index is addr[AW+1:2], other bits ignored
//   byte_en  - byte-lane write mask; bit i covers data bits 8i+7..8i
//   data_in  - store data, already lane-aligned by the CPU
//   data_out - registered load data (full word, never masked)
//
// Parameters:
//   DATA_WIDTH must be 32 (four byte lanes); DEPTH must be a power of two.

module dmem_byte_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RD,
  input  logic                  WR,
  input  logic [31:0]           addr,
  input  logic [3:0]            byte_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [AW-1:0] idx;

  // The low two bits select a byte within the word, and the CPU handles that.
  // The high bits beyond the array size are dropped, so addresses wrap
  // modulo DEPTH*4 bytes.
  assign idx = addr[AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  // Byte-lane write port. rst is in the sensitivity list only so that a
  // store coinciding with reset assertion is dropped. The array itself is
  // never cleared, so preloaded contents survive a reset pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
    end else if (WR) begin
      for (int i = 0; i < LANES; i++) begin
        if (byte_en[i]) begin
          mem[idx][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  // Registered read port. It samples the array before this edge's write
  // takes effect, which gives read-first behaviour when a load and a store
  // hit the same word on one edge. When RD is low, data_out holds its value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (RD) begin
      data_out <= mem[idx];
    end
  end

endmodule

// File: tb/tb_dmem_byte_ram.sv
// tb_dmem_byte_ram
// Scoreboarded bench for dmem_byte_ram. Each issued read pushes its
// hand-computed expected word into a queue. A separate monitor pops that
// queue and compares on the falling edge after every accepted read. Reset,
// hold, mem-content and async-reset checks are made directly.

module tb_dmem_byte_ram;

  logic        clk;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [3:0]  byte_en;
  logic [31:0] data_in;
  logic [31:0] data_out;

  logic [31:0] exp_q [$];
  logic        rd_seen;
  int          check_count;
  int          error_count;

  dmem_byte_ram #(
    .DATA_WIDTH(32),
    .DEPTH     (256)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .RD      (rd),
    .WR      (wr),
    .addr    (addr),
    .byte_en (byte_en),
    .data_in (data_in),
    .data_out(data_out)
  );

  // Free-running clock with a 10-time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value, count it, and report any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge. If this cycle issues a
  // read, the expected word is queued for the monitor.
  task automatic applyStimulus(input logic r, input logic w,
                               input logic [31:0] a, input logic [3:0] be,
                               input logic [31:0] d, input logic [31:0] exp_rd);
    @(negedge clk);
    rd      = r;
    wr      = w;
    addr    = a;
    byte_en = be;
    data_in = d;
    if (r && !rst) exp_q.push_back(exp_rd);
  endtask

  // Record whether the DUT accepted a read on this rising edge.
  always @(posedge clk) begin
    rd_seen <= rd && !rst;
  end

  // Monitor: after every accepted read, pop the expected word and compare.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        check_count++;
        error_count++;
        $display("[TB] FAIL sb_underflow: got %08h, expected none queued", data_out);
      end else begin
        checkOutput("sb_read", data_out, exp_q.pop_front());
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    check_count = 0;
    error_count = 0;
    rd_seen     = 1'b0;
    rst         = 1'b1;
    rd          = 1'b0;
    wr          = 1'b0;
    addr        = '0;
    byte_en     = '0;
    data_in     = '0;

    dut.mem[0]  = 32'h0000_0000;
    dut.mem[5]  = 32'h0000_0001;
    dut.mem[34] = 32'h1122_3344;
    dut.mem[35] = 32'hDEAD_BEEF;

    repeat (2) @(negedge clk);
    checkOutput("reset_dout", data_out, 32'h0);
    rst = 1'b0;

    // Preloaded word survives reset.
    applyStimulus(1, 0, 32'h88, 4'b0000, 32'h0, 32'h1122_3344);

    // Full-word store, then load.
    applyStimulus(0, 1, 32'h8C, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    applyStimulus(1, 0, 32'h8C, 4'b0000, 32'h0, 32'hDEAD_BEEF);

    // Byte and halfword lane writes.
    applyStimulus(0, 1, 32'h8C, 4'b0100, 32'h00AA_0000, 32'h0);
    applyStimulus(1, 0, 32'h8C, 4'b0000, 32'h0, 32'hDEAA_BEEF);
    applyStimulus(0, 1, 32'h8C, 4'b0011, 32'h0000_1234, 32'h0);
    applyStimulus(1, 0, 32'h8C, 4'b0000, 32'h0, 32'hDEAA_1234);

    // A store with an empty mask changes nothing.
    applyStimulus(0, 1, 32'h8C, 4'b0000, 32'hFFFF_FFFF, 32'h0);
    applyStimulus(1, 0, 32'h8C, 4'b1111, 32'h0, 32'hDEAA_1234);

    // Read-first collision on the same word.
    applyStimulus(1, 1, 32'h14, 4'b1111, 32'h0000_0002, 32'h0000_0001);
    applyStimulus(1, 0, 32'h14, 4'b0000, 32'h0, 32'h0000_0002);

    // Address wrap, with the low address bits ignored.
    applyStimulus(0, 1, 32'h403, 4'b1111, 32'h5A5A_5A5A, 32'h0);
    applyStimulus(1, 0, 32'h0, 4'b0000, 32'h0, 32'h5A5A_5A5A);
    applyStimulus(1, 0, 32'h8000_0402, 4'b0000, 32'h0, 32'h5A5A_5A5A);

    // data_out holds its value while RD is low.
    applyStimulus(0, 0, 32'h88, 4'b0000, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold_dout", data_out, 32'h5A5A_5A5A);
    end

    // Asynchronous reset between edges, with a store and a load attempted.
    rd      = 1'b1;
    wr      = 1'b1;
    addr    = 32'h88;
    byte_en = 4'b1111;
    data_in = 32'hFFFF_FFFF;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_dout", data_out, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("rst_dout_held", data_out, 32'h0);
    checkOutput("mem34_kept", dut.mem[34], 32'h1122_3344);
    checkOutput("mem35_kept", dut.mem[35], 32'hDEAA_1234);
    checkOutput("mem5_kept", dut.mem[5], 32'h0000_0002);
    checkOutput("mem0_kept", dut.mem[0], 32'h5A5A_5A5A);
    rd  = 1'b0;
    wr  = 1'b0;
    rst = 1'b0;

    applyStimulus(1, 0, 32'h88, 4'b0000, 32'h0, 32'h1122_3344);
    applyStimulus(0, 0, 32'h0, 4'b0000, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
